// File: rtl/p15_pkg.sv
// Shared constants for the p15 mixer/DAC: R7 bit positions, amplitude register layout
// and the logarithmic volume table.
package p15_pkg;

    localparam int unsigned TONE_DIS_A  = 0;
    localparam int unsigned TONE_DIS_B  = 1;
    localparam int unsigned TONE_DIS_C  = 2;
    localparam int unsigned NOISE_DIS_A = 3;
    localparam int unsigned NOISE_DIS_B = 4;
    localparam int unsigned NOISE_DIS_C = 5;

    localparam int unsigned AMP_ENV_BIT = 4;

    // Roughly 3 dB per step, level 0 is silent
    localparam logic [7:0] LOG_TABLE [16] = '{
        8'd0,  8'd2,  8'd3,  8'd4,  8'd6,   8'd8,   8'd11,  8'd16,
        8'd23, 8'd32, 8'd45, 8'd64, 8'd90, 8'd127, 8'd180, 8'd255
    };

    function automatic logic [7:0] log_level(input logic [3:0] vol);
        return LOG_TABLE[vol];
    endfunction

endpackage

// File: rtl/p15_mixer_dac_if.sv
// Generator/register bus feeding the mixer: tone and noise square waves, R7 mixer
// enables, the three amplitude registers and the current envelope level.
interface p15_mixer_dac_if;

    logic       tone_a;
    logic       tone_b;
    logic       tone_c;
    logic       noise;
    logic [5:0] mixer;
    logic [4:0] amp_a;
    logic [4:0] amp_b;
    logic [4:0] amp_c;
    logic [3:0] envelope;

    modport master (
        output tone_a, tone_b, tone_c, noise, mixer, amp_a, amp_b, amp_c, envelope
    );

    modport slave (
        input tone_a, tone_b, tone_c, noise, mixer, amp_a, amp_b, amp_c, envelope
    );

endinterface

// File: rtl/p15_volume_lut.sv
// Combinational 4-bit volume to linear sample map. Log table when P15_LOG_VOLUME_EN is
// defined, otherwise linear vol*17.
module p15_volume_lut
    import p15_pkg::*;
#(
    parameter int unsigned LEVEL_BITS = 8
) (
    input  logic [3:0]            vol,
    output logic [LEVEL_BITS-1:0] level
);

    logic [7:0] raw;

`ifdef P15_LOG_VOLUME_EN
    assign raw = log_level(vol);
`else
    // vol*17 is the nibble repeated twice
    assign raw = {vol, vol};
`endif

    assign level = LEVEL_BITS'(raw);

endmodule

// File: rtl/p15_mixer_dac.sv
// AY-3-8913 mixer, volume stage and 1-bit PWM DAC. Volume curve selected by
// P15_LOG_VOLUME_EN (log when defined, linear otherwise).
module p15_mixer_dac
    import p15_pkg::*;
#(
    parameter int unsigned LEVEL_BITS  = 8,
    parameter int unsigned MASTER_BITS = 10
) (
    input  logic                   clk,
    input  logic                   reset,
    p15_mixer_dac_if.slave         psg,
    output logic [LEVEL_BITS-1:0]  level_a,
    output logic [LEVEL_BITS-1:0]  level_b,
    output logic [LEVEL_BITS-1:0]  level_c,
    output logic [MASTER_BITS-1:0] master,
    output logic                   pwm_out
);

    logic                   gate_a, gate_b, gate_c;
    logic [3:0]             vol_a, vol_b, vol_c;
    logic [LEVEL_BITS-1:0]  lut_a, lut_b, lut_c;
    logic [MASTER_BITS-1:0] pwm_cnt;
    logic [MASTER_BITS-1:0] duty;

    // A disabled source reads as 1, so both disabled gives a DC level for sample playback
    assign gate_a = (psg.tone_a | psg.mixer[TONE_DIS_A]) & (psg.noise | psg.mixer[NOISE_DIS_A]);
    assign gate_b = (psg.tone_b | psg.mixer[TONE_DIS_B]) & (psg.noise | psg.mixer[NOISE_DIS_B]);
    assign gate_c = (psg.tone_c | psg.mixer[TONE_DIS_C]) & (psg.noise | psg.mixer[NOISE_DIS_C]);

    always_comb begin
        vol_a = 4'd0;
        vol_b = 4'd0;
        vol_c = 4'd0;
        if (gate_a) vol_a = psg.amp_a[AMP_ENV_BIT] ? psg.envelope : psg.amp_a[3:0];
        if (gate_b) vol_b = psg.amp_b[AMP_ENV_BIT] ? psg.envelope : psg.amp_b[3:0];
        if (gate_c) vol_c = psg.amp_c[AMP_ENV_BIT] ? psg.envelope : psg.amp_c[3:0];
    end

    p15_volume_lut #(.LEVEL_BITS(LEVEL_BITS)) u_lut_a (.vol(vol_a), .level(lut_a));
    p15_volume_lut #(.LEVEL_BITS(LEVEL_BITS)) u_lut_b (.vol(vol_b), .level(lut_b));
    p15_volume_lut #(.LEVEL_BITS(LEVEL_BITS)) u_lut_c (.vol(vol_c), .level(lut_c));

    always_ff @(posedge clk) begin
        if (reset) begin
            level_a <= '0;
            level_b <= '0;
            level_c <= '0;
            master  <= '0;
            pwm_cnt <= '0;
            duty    <= '0;
            pwm_out <= 1'b0;
        end else begin
            level_a <= lut_a;
            level_b <= lut_b;
            level_c <= lut_c;
            master  <= MASTER_BITS'(level_a) + MASTER_BITS'(level_b) + MASTER_BITS'(level_c);
            pwm_cnt <= pwm_cnt + MASTER_BITS'(1);
            // Duty only reloads at the period boundary so pulses are never cut short
            if (&pwm_cnt) duty <= master;
            pwm_out <= (pwm_cnt < duty);
        end
    end

endmodule

// File: tb/tb_p15_mixer_dac.sv
// Directed self-checking bench for p15_mixer_dac; expected levels follow the build's
// volume curve (P15_LOG_VOLUME_EN).
module tb_p15_mixer_dac;

    localparam int unsigned LEVEL_BITS  = 8;
    localparam int unsigned MASTER_BITS = 10;
    localparam int          PERIOD      = 1 << MASTER_BITS;

    logic                   clk = 1'b0;
    logic                   reset;
    logic [LEVEL_BITS-1:0]  level_a, level_b, level_c;
    logic [MASTER_BITS-1:0] master;
    logic                   pwm_out;

    int n_checks = 0;
    int n_fail   = 0;
    int phase    = 0;  // expected pwm_cnt after the latest edge
    int highs;

    p15_mixer_dac_if psg ();

    p15_mixer_dac #(
        .LEVEL_BITS  (LEVEL_BITS),
        .MASTER_BITS (MASTER_BITS)
    ) dut (
        .clk     (clk),
        .reset   (reset),
        .psg     (psg),
        .level_a (level_a),
        .level_b (level_b),
        .level_c (level_c),
        .master  (master),
        .pwm_out (pwm_out)
    );

    always #5 clk = ~clk;

    function automatic int exp_level(input int v);
`ifdef P15_LOG_VOLUME_EN
        case (v)
            0: return 0;     1: return 2;     2: return 3;     3: return 4;
            4: return 6;     5: return 8;     6: return 11;    7: return 16;
            8: return 23;    9: return 32;    10: return 45;   11: return 64;
            12: return 90;   13: return 127;  14: return 180;  default: return 255;
        endcase
`else
        return v * 17;
`endif
    endfunction

    task automatic check_eq(input string tag, input int obs, input int exp);
        n_checks++;
        if (obs != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        if (reset) phase = 0;
        else phase = (phase + 1) % PERIOD;
    endtask

    task automatic sync_period();
        tick();
        while (phase != 0) tick();
    endtask

    // Counts pwm_out highs over one period; call when phase == 0
    task automatic count_period(output int h);
        h = 0;
        repeat (PERIOD) begin
            tick();
            h += int'(pwm_out);
        end
    endtask

    task automatic set_inputs(input logic ta, input logic tb, input logic tc, input logic nz,
                              input logic [5:0] mx, input logic [4:0] aa,
                              input logic [4:0] ab, input logic [4:0] ac,
                              input logic [3:0] env);
        psg.tone_a   = ta;
        psg.tone_b   = tb;
        psg.tone_c   = tc;
        psg.noise    = nz;
        psg.mixer    = mx;
        psg.amp_a    = aa;
        psg.amp_b    = ab;
        psg.amp_c    = ac;
        psg.envelope = env;
    endtask

    initial begin
        // Reset with every input high
        reset = 1'b1;
        set_inputs(1, 1, 1, 1, 6'h3f, 5'h1f, 5'h1f, 5'h1f, 4'hf);
        repeat (3) tick();
        check_eq("rst_level_a", int'(level_a), 0);
        check_eq("rst_level_b", int'(level_b), 0);
        check_eq("rst_level_c", int'(level_c), 0);
        check_eq("rst_master", int'(master), 0);
        check_eq("rst_pwm", int'(pwm_out), 0);
        reset = 1'b0;
        count_period(highs);
        check_eq("first_period_low", highs, 0);
        count_period(highs);
        check_eq("full_after_reset", highs, 765);

        // DC playback on channel A
        set_inputs(0, 0, 0, 0, 6'h3f, 5'h0f, 5'h00, 5'h00, 4'h0);
        tick();
        check_eq("dc_level_a", int'(level_a), 255);
        check_eq("dc_level_b", int'(level_b), 0);
        tick();
        check_eq("dc_master", int'(master), 255);
        sync_period();
        count_period(highs);
        check_eq("dc_pwm_high", highs, 255);

        // Tone gating on A, with the 1-clk lag checked before each edge
        set_inputs(0, 0, 0, 0, 6'h3e, 5'h08, 5'h00, 5'h00, 4'h0);
        tick();
        for (int i = 0; i < 6; i++) begin
            logic prev_tone;
            prev_tone = psg.tone_a;
            psg.tone_a = ~psg.tone_a;
            #2;
            check_eq("tone_lag", int'(level_a), prev_tone ? exp_level(8) : 0);
            tick();
            check_eq("tone_level_a", int'(level_a), psg.tone_a ? exp_level(8) : 0);
        end

        // Envelope sweep on B; fixed-level bits deliberately non-zero
        psg.mixer = 6'h3f;
        psg.amp_a = 5'h00;
        for (int e = 0; e < 16; e++) begin
            psg.envelope = 4'(e);
            psg.amp_b    = {1'b1, 4'(15 - e)};
            tick();
            check_eq("env_level_b", int'(level_b), exp_level(e));
        end

        // Mixed sum
        set_inputs(0, 0, 0, 0, 6'h3f, 5'h04, 5'h08, 5'h0c, 4'h0);
        repeat (2) tick();
        check_eq("mix_master", int'(master), exp_level(4) + exp_level(8) + exp_level(12));

        // Full scale, then drop to silence mid-period
        set_inputs(0, 0, 0, 0, 6'h3f, 5'h0f, 5'h0f, 5'h0f, 4'h0);
        repeat (2) tick();
        check_eq("full_master", int'(master), 765);
        sync_period();
        highs = 0;
        for (int i = 1; i <= PERIOD; i++) begin
            tick();
            highs += int'(pwm_out);
            if (i == 500) begin
                psg.amp_a = 5'h00;
                psg.amp_b = 5'h00;
                psg.amp_c = 5'h00;
            end
        end
        check_eq("hold_period_high", highs, 765);
        count_period(highs);
        check_eq("after_drop_high", highs, 0);

        // Tone AND noise on C
        set_inputs(0, 0, 1, 0, 6'h00, 5'h00, 5'h00, 5'h0f, 4'h0);
        tick();
        check_eq("and_noise0", int'(level_c), 0);
        psg.noise = 1'b1;
        tick();
        check_eq("and_both1", int'(level_c), 255);
        psg.tone_c = 1'b0;
        tick();
        check_eq("and_tone0", int'(level_c), 0);
        psg.tone_c = 1'b1;

        // Reset mid-period with a loud channel: the next period must still be silent
        repeat (300) tick();
        check_eq("pre_rst_pwm_period", int'(master), 255);
        reset = 1'b1;
        tick();
        check_eq("mid_rst_level_c", int'(level_c), 0);
        check_eq("mid_rst_master", int'(master), 0);
        check_eq("mid_rst_pwm", int'(pwm_out), 0);
        reset = 1'b0;
        count_period(highs);
        check_eq("post_rst_low", highs, 0);
        count_period(highs);
        check_eq("post_rst_valid", highs, 255);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
